// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Brief    : Shared types and sizing for the multiply/divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  // MULT and DIV interpret operands as two's complement
  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_step
// Brief    : One iteration of the shared multiply/divide datapath.
//            Multiply: radix-2 shift-add, acc = {partial_hi, multiplier}.
//            Divide  : restoring shift-subtract, acc = {remainder, quotient}.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] rem_diff;

  // Compute one multiply or divide step; the extra bit holds the add carry
  // or the subtract borrow, and is folded back into the 2*WIDTH result.
  always_comb begin
    mul_sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
             + ({(WIDTH+1){acc_in[0]}} & {1'b0, operand});
    rem_sh   = acc_in[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, operand};
    if (is_div) begin
      if (!rem_diff[WIDTH]) begin
        acc_out = {rem_diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//            Load in IDLE, WIDTH iterations in MUL/DIV, sign fix and HI/LO
//            write in FIX. Stalls execute while an operation is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 sign_p_q, sign_p_d;   // product / quotient sign
  logic                 sign_r_q, sign_r_d;   // remainder sign
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  mdu_op_t              op_e;
  logic                 signed_op;
  logic                 load_div;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .operand (opnd_q),
    .acc_out (step_acc)
  );

  // Next-state logic: operand load, iteration, sign fix and flush handling
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sign_p_d = sign_p_q;
    sign_r_d = sign_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    op_e      = mdu_op_t'(op);
    signed_op = op_is_signed(op_e);
    load_div  = op_is_div(op_e);
    rs_mag    = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_mag    = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // The product is negated as one double-width value; quotient and
    // remainder carry independent signs.
    prod_fix  = sign_p_q ? -acc_q : acc_q;
    quo_fix   = sign_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          is_div_d = load_div;
          sign_p_d = signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          sign_r_d = signed_op & rs_val[WIDTH-1];
          // Multiply shifts the multiplier out of the low half; divide
          // shifts the dividend out of it.
          opnd_d   = load_div ? rt_mag : rs_mag;
          acc_d    = {{WIDTH{1'b0}}, (load_div ? rs_mag : rt_mag)};
          cnt_d    = '0;
          state_d  = load_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_CNT_LAST) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers; reset clears everything at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_p_q <= 1'b0;
      sign_r_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sign_p_q <= sign_p_d;
      sign_r_q <= sign_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // Zero-latency pipeline hold for a second issue or an MFHI/MFLO
  assign stall = busy_q & (start | mf_req);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Self-checking bench for muldiv_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
  import mips_pkg::*;

  localparam int W       = 32;
  localparam int LATENCY = 33;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [1:0]   op      = 2'd0;
  logic [W-1:0] rs_val  = '0;
  logic [W-1:0] rt_val  = '0;
  logic         mf_req  = 1'b0;
  logic         flush   = 1'b0;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  exp_t sb [$];

  always #5 clock = ~clock;

  muldiv_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mf_req  (mf_req),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; start is sampled on the next rising edge (E0)
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    if (track) begin
      e.hi = eh;
      e.lo = el;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts rising edges after E0 until done is seen, with a cycle budget
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required within 40", name, cyc);
    end
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: result hi=%h lo=%h with no expected entry", name, hi, lo);
    end else begin
      e = sb.pop_front();
      chk({name, "_hi"}, hi, e.hi);
      chk({name, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int stall_bad;
    bit seen_done;

    //                op        rs            rt            exp_hi        exp_lo
    vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'd0, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'd0, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
    vecs[6]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{2'd2, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'h00000001};
    vecs[10] = '{2'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[11] = '{2'd1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset_n = 1'b1;
    @(negedge clock);
    mf_req = 1'b1;
    #1;
    chk("idle_stall", stall, 0);
    mf_req = 1'b0;
    @(negedge clock);

    // Table of operations, one at a time
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b1, vecs[i].exp_hi, vecs[i].exp_lo);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_early_done", i), done, 0);
      wait_done($sformatf("v%0d", i), cyc);
      chk($sformatf("v%0d_latency", i), cyc, LATENCY);
      check_result($sformatf("v%0d", i));
      chk($sformatf("v%0d_busy_after", i), busy, 0);
      @(negedge clock);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Back-to-back: DIV issued in the cycle done is visible
    issue(2'd0, 32'hFFFFFFF9, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    wait_done("b2b_first", cyc);
    check_result("b2b_first");
    issue(2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    chk("b2b_accepted", busy, 1);
    chk("b2b_done_pulse", done, 0);
    wait_done("b2b_second", cyc);
    chk("b2b_latency", cyc, LATENCY);
    check_result("b2b_second");
    @(negedge clock);

    // mf_req from E5, ignored start at E10, MULT 6 x 7
    issue(2'd0, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
    cyc = 0;
    stall_bad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 4) mf_req = 1'b1;
      if (cyc == 9) begin
        start  = 1'b1;
        op     = 2'd1;
        rs_val = 32'd2;
        rt_val = 32'd2;
      end
      if (cyc == 10) start = 1'b0;
      @(negedge clock);
      cyc++;
      if (cyc >= 5 && cyc <= 32 && stall !== 1'b1) stall_bad++;
    end
    chk("mf_stall_hold", stall_bad, 0);
    chk("mf_latency", cyc, LATENCY);
    chk("mf_stall_release", stall, 0);
    check_result("mf_mult");
    mf_req = 1'b0;
    @(negedge clock);
    chk("mf_start_ignored_busy", busy, 0);
    chk("mf_start_ignored_lo", lo, 32'd42);

    // Flush at E20 of DIVU 9 / 2 with lo=42
    issue(2'd3, 32'd9, 32'd2, 1'b0, '0, '0);
    repeat (19) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_lo", lo, 32'd42);
    chk("flush_hi", hi, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("flush_no_done", seen_done, 0);

    // Flush wins over start in IDLE
    start  = 1'b1;
    flush  = 1'b1;
    op     = 2'd3;
    rs_val = 32'd9;
    rt_val = 32'd2;
    @(negedge clock);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_dropped", busy, 0);

    // Asynchronous reset at E15 of a MULTU
    issue(2'd1, 32'd5, 32'd5, 1'b0, '0, '0);
    repeat (14) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_hi", hi, 0);
    chk("areset_lo", lo, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    issue(2'd1, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    wait_done("post_reset", cyc);
    chk("post_reset_latency", cyc, LATENCY);
    check_result("post_reset");
    @(negedge clock);

    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer that replaces the single-cycle `*`, `/` and `%` operators of the execute stage, and owns the architectural HI/LO registers. Execute issues MULT/MULTU/DIV/DIVU with a one-cycle start pulse. The block iterates a shared shift/add-subtract datapath for 32 cycles and writes HI/LO. It stalls the pipeline when a second mult/div or an MFHI/MFLO arrives while an operation is in flight.

## Interface
- `WIDTH`, 32: operand, HI and LO width; iteration count equals `WIDTH`.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  issue request from execute; sampled only in IDLE.
- `op`  in  2  operation: MULT=0, MULTU=1, DIV=2, DIVU=3.
- `rs_val`  in  WIDTH  multiplicand / dividend, post-bypass.
- `rt_val`  in  WIDTH  multiplier / divisor, post-bypass.
- `mf_req`  in  1  an MFHI/MFLO is in execute this cycle.
- `flush`  in  1  squash the in-flight operation (branch/jump redirect).
- `busy`  out  1  operation in flight; high in every state except IDLE.
- `done`  out  1  one-cycle pulse on the cycle HI/LO first show the new result.
- `stall`  out  1  `busy & (start | mf_req)`; combinational; freezes fetch, decode and execute.
- `hi`  out  WIDTH  HI register (remainder, or upper product).
- `lo`  out  WIDTH  LO register (quotient, or lower product).

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0; state is IDLE; counter is 0.
- States and transitions:
  - IDLE -> MUL on `start` with op 0 or 1.
  - IDLE -> DIV on `start` with op 2 or 3.
  - MUL/DIV -> FIX when the counter reaches `WIDTH-1`.
  - FIX -> IDLE unconditionally.
- IDLE load, on the `start` edge:
  - Latch operand magnitudes. Signed ops take the absolute value; unsigned ops pass operands through.
  - Latch the result-sign flags: product sign = `rs[31]^rt[31]`; quotient sign = `rs[31]^rt[31]`; remainder sign = `rs[31]`.
  - Clear the accumulator and the counter.
- MUL, one step per cycle: radix-2 shift-add over a 2×WIDTH accumulator. This is WIDTH+1 bits internally to hold the carry.
- DIV, one step per cycle: restoring shift-subtract producing quotient and remainder magnitudes.
- FIX:
  - Apply the sign flags by two's-complement negation: the product is negated as 64 bits; quotient and remainder are negated separately.
  - Write HI/LO.
  - Assert `done` for the following cycle.
- Divisor zero:
  - Full latency; no exception.
  - Unsigned: `lo`=all ones, `hi`=`rs_val`.
  - Signed: `lo` = ±all ones after sign fix, `hi`=`rs_val`. This is the natural restoring result; no special-case logic.
- Signed `0x80000000 / -1`: `lo`=`0x80000000`, `hi`=0.
- `start` while `busy` is ignored (never queued). Execute re-presents it because `stall` holds the instruction.
- `flush` has priority over `start` in the same cycle.
  - In MUL, DIV or FIX: return to IDLE on the next edge; HI/LO keep their old values; no `done`.
  - In IDLE with `start`: the start is dropped.
- `hi`/`lo` are read directly by execute for MFHI/MFLO. Their values are valid whenever `busy`=0.

## Timing
- `start` sampled at edge E0.
- Iteration edges E1..E32.
- FIX writes HI/LO at E33. From E33 onward, `busy`=0, `done`=1 for one cycle, and HI/LO hold the new value.
- Issue-to-result latency is 33 cycles. A new `start` is accepted at E33 (back-to-back issue).
- An MFHI issued during E1..E32 stalls. It executes in the cycle after E33 and reads the new value.
- `stall` has zero-cycle latency from `mf_req`/`start`.
- Reset asserted mid-operation: immediately IDLE; HI/LO=0; `done`=0. No partial write.

## Structure
- Shared package `mips_pkg`:
  - `mdu_op_t` enum (MULT, MULTU, DIV, DIVU).
  - `mdu_state_t` enum (IDLE, MUL, DIV, FIX).
  - `MDU_CNT_W = $clog2(WIDTH)`.
- One sub-module, `mdu_step`: a combinational single-iteration datapath. Mode input selects multiply or divide; it takes the accumulator plus operand and returns the next accumulator. The FSM, counter, sign fix and HI/LO registers stay in `muldiv_seq`.

## Test plan
- MULTU `0xFFFFFFFF × 0xFFFFFFFF` -> after 33 cycles, `hi`=`0xFFFFFFFE`, `lo`=`0x00000001`, `done` high exactly one cycle.
- MULT `-7 × 3`, then DIV `-7 / 2` issued at E33:
  - First result: `hi`=`0xFFFFFFFF`, `lo`=`0xFFFFFFEB`.
  - Second result: `lo`=`0xFFFFFFFD`, `hi`=`0xFFFFFFFF`.
  - No idle cycle between the two operations.
- DIVU `100 / 0` -> `lo`=`0xFFFFFFFF`, `hi`=`100`. Signed DIV `0x80000000 / -1` -> `lo`=`0x80000000`, `hi`=0.
- `mf_req` at E5 of a MULT `6 × 7`:
  - `stall`=1 through E32.
  - At E33, `stall`=0 and `lo`=42.
  - A second `start` at E10 is ignored.
- `flush` at E20 of DIVU `9 / 2` with prior `lo`=42 -> `busy`=0 next cycle, `lo` stays 42, no `done`.
- `reset_n` low at E15 -> `busy`/`done`/`hi`/`lo` go to 0 asynchronously. After release, a fresh MULTU `2 × 3` gives `lo`=6.
